// File: rtl/vram_bus_arbiter.sv
// vram_bus_arbiter: shares one SRAM port between a 6800-class CPU and the
// VPU DMA initiator. The CPU is halted on VPU hold, the port is handed to
// the DMA after cpu_ba (with GUARD dead cycles), then returned.
// Optional HALT timeout is compiled in with `define VRAM_ARB_TIMEOUT_EN.
module vram_bus_arbiter #(
    parameter int AW    = 16,
    parameter int DW    = 8,
    parameter int GUARD = 1,
    parameter int TMO   = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    input  logic          cpu_vma,
    input  logic          cpu_ba,
    output logic          cpu_halt,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_hold,
    input  logic          dma_cs,
    input  logic [AW-1:0] dma_addr,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_grant,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [7:0]    dma_reads,
    output logic          tmo_err
);

    generate
        if (GUARD < 0 || GUARD > 3) begin : g_bad_guard
            $error("vram_bus_arbiter: GUARD must be 0..3");
        end
        if (TMO < 1 || TMO > 255) begin : g_bad_tmo
            $error("vram_bus_arbiter: TMO must be 1..255");
        end
    endgenerate

    // Last guard count value before leaving a guard state
    localparam logic [1:0] GLAST = 2'((GUARD > 0) ? GUARD - 1 : 0);

    typedef enum logic [2:0] {
        S_CPU, S_HALT, S_GUARD_IN, S_GRANT, S_GUARD_OUT
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    gcnt, gcnt_nxt;
    logic [7:0]    rcnt, rcnt_nxt;
    logic [7:0]    dma_reads_nxt;
    logic          cpu_halt_nxt, dma_grant_nxt;
    logic          cpu_owns;
    logic [DW-1:0] cpu_rdata_q;
    logic          hold_req;
    logic          tmo_fire;

`ifdef VRAM_ARB_TIMEOUT_EN
    localparam logic [7:0] TLAST = 8'(TMO - 1);
    logic [7:0] tcnt;
    logic       hold_block;
    logic       tmo_err_q;

    // A hold that timed out is ignored until the VPU lets go of it
    assign hold_req = dma_hold && !hold_block;
    // Hold drop and cpu_ba both take priority over the timeout
    assign tmo_fire = (state == S_HALT) && dma_hold && !cpu_ba && (tcnt == TLAST);
    assign tmo_err  = tmo_err_q;

    // HALT dwell counter, sticky error and hold blocking
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt       <= 8'd0;
            hold_block <= 1'b0;
            tmo_err_q  <= 1'b0;
        end else begin
            tcnt <= (state == S_HALT) ? tcnt + 8'd1 : 8'd0;
            if (tmo_fire) begin
                tmo_err_q  <= 1'b1;
                hold_block <= 1'b1;
            end else if (!dma_hold) begin
                hold_block <= 1'b0;
            end
        end
    end
`else
    assign hold_req = dma_hold;
    assign tmo_fire = 1'b0;
    assign tmo_err  = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_CPU;
            gcnt      <= 2'd0;
            rcnt      <= 8'd0;
            dma_reads <= 8'd0;
            cpu_halt  <= 1'b0;
            dma_grant <= 1'b0;
        end else begin
            state     <= state_nxt;
            gcnt      <= gcnt_nxt;
            rcnt      <= rcnt_nxt;
            dma_reads <= dma_reads_nxt;
            cpu_halt  <= cpu_halt_nxt;
            dma_grant <= dma_grant_nxt;
        end
    end

    // Next state and memory port steering
    always_comb begin
        state_nxt     = state;
        gcnt_nxt      = gcnt;
        rcnt_nxt      = rcnt;
        dma_reads_nxt = dma_reads;
        cpu_halt_nxt  = cpu_halt;
        dma_grant_nxt = dma_grant;
        cpu_owns      = 1'b0;
        mem_addr      = cpu_addr;
        mem_wdata     = cpu_wdata;
        mem_cs        = 1'b0;
        mem_we        = 1'b0;
        case (state)
            S_CPU: begin
                cpu_owns = 1'b1;
                mem_cs   = cpu_vma;
                mem_we   = cpu_we & cpu_vma;
                if (hold_req) begin
                    state_nxt    = S_HALT;
                    cpu_halt_nxt = 1'b1;
                end
            end
            S_HALT: begin
                // CPU finishes its current cycle on the port untouched
                cpu_owns = 1'b1;
                mem_cs   = cpu_vma;
                mem_we   = cpu_we & cpu_vma;
                if (!dma_hold) begin
                    state_nxt    = S_CPU;
                    cpu_halt_nxt = 1'b0;
                end else if (cpu_ba) begin
                    if (GUARD == 0) begin
                        state_nxt     = S_GRANT;
                        dma_grant_nxt = 1'b1;
                    end else begin
                        state_nxt = S_GUARD_IN;
                        gcnt_nxt  = 2'd0;
                    end
                end else if (tmo_fire) begin
                    state_nxt    = S_CPU;
                    cpu_halt_nxt = 1'b0;
                end
            end
            S_GUARD_IN: begin
                if (gcnt == GLAST) begin
                    state_nxt     = S_GRANT;
                    dma_grant_nxt = 1'b1;
                    gcnt_nxt      = 2'd0;
                end else begin
                    gcnt_nxt = gcnt + 2'd1;
                end
            end
            S_GRANT: begin
                // DMA is read-only; cpu_ba is not watched once granted
                mem_addr = dma_addr;
                mem_cs   = dma_cs;
                if (!dma_hold) begin
                    dma_reads_nxt = rcnt;
                    rcnt_nxt      = 8'd0;
                    dma_grant_nxt = 1'b0;
                    if (GUARD == 0) begin
                        state_nxt    = S_CPU;
                        cpu_halt_nxt = 1'b0;
                    end else begin
                        state_nxt = S_GUARD_OUT;
                        gcnt_nxt  = 2'd0;
                    end
                end else if (dma_cs && rcnt != 8'hFF) begin
                    rcnt_nxt = rcnt + 8'd1;
                end
            end
            S_GUARD_OUT: begin
                if (gcnt == GLAST) begin
                    state_nxt    = S_CPU;
                    cpu_halt_nxt = 1'b0;
                    gcnt_nxt     = 2'd0;
                end else begin
                    gcnt_nxt = gcnt + 2'd1;
                end
            end
            default: state_nxt = S_CPU;
        endcase
        // No select while reset is being applied, even mid-grant
        if (rst) begin
            mem_cs = 1'b0;
            mem_we = 1'b0;
        end
    end

    // Hold the last CPU-visible read data while the CPU is off the port
    always_ff @(posedge clk) begin
        if (rst)           cpu_rdata_q <= '0;
        else if (cpu_owns) cpu_rdata_q <= mem_rdata;
    end

    assign cpu_rdata = cpu_owns ? mem_rdata : cpu_rdata_q;
    assign dma_rdata = dma_grant ? mem_rdata : '1;

endmodule

// File: tb/tb_vram_bus_arbiter.sv
// Bench for vram_bus_arbiter: two instances (GUARD=0 and GUARD=2, TMO=10)
// share all inputs; expected values are queued when stimulus is driven and
// popped when the outputs are sampled on the falling edge.
module tb_vram_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr, dma_addr;
    logic [7:0]  cpu_wdata, mem_rdata;
    logic        cpu_we, cpu_vma, cpu_ba, dma_hold, dma_cs;

    logic        cpu_halt_g0, dma_grant_g0, mem_cs_g0, mem_we_g0, tmo_err_g0;
    logic [7:0]  cpu_rdata_g0, dma_rdata_g0, mem_wdata_g0, dma_reads_g0;
    logic [15:0] mem_addr_g0;
    logic        cpu_halt_g2, dma_grant_g2, mem_cs_g2, mem_we_g2, tmo_err_g2;
    logic [7:0]  cpu_rdata_g2, dma_rdata_g2, mem_wdata_g2, dma_reads_g2;
    logic [15:0] mem_addr_g2;

    int          vecs = 0;
    int          errs = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    always #5 clk = ~clk;

    vram_bus_arbiter #(.AW(16), .DW(8), .GUARD(0), .TMO(10)) u_g0 (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_we(cpu_we), .cpu_vma(cpu_vma), .cpu_ba(cpu_ba), .cpu_halt(cpu_halt_g0),
        .cpu_rdata(cpu_rdata_g0), .dma_hold(dma_hold), .dma_cs(dma_cs),
        .dma_addr(dma_addr), .dma_rdata(dma_rdata_g0), .dma_grant(dma_grant_g0),
        .mem_addr(mem_addr_g0), .mem_wdata(mem_wdata_g0), .mem_rdata(mem_rdata),
        .mem_cs(mem_cs_g0), .mem_we(mem_we_g0), .dma_reads(dma_reads_g0),
        .tmo_err(tmo_err_g0)
    );

    vram_bus_arbiter #(.AW(16), .DW(8), .GUARD(2), .TMO(10)) u_g2 (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_we(cpu_we), .cpu_vma(cpu_vma), .cpu_ba(cpu_ba), .cpu_halt(cpu_halt_g2),
        .cpu_rdata(cpu_rdata_g2), .dma_hold(dma_hold), .dma_cs(dma_cs),
        .dma_addr(dma_addr), .dma_rdata(dma_rdata_g2), .dma_grant(dma_grant_g2),
        .mem_addr(mem_addr_g2), .mem_wdata(mem_wdata_g2), .mem_rdata(mem_rdata),
        .mem_cs(mem_cs_g2), .mem_we(mem_we_g2), .dma_reads(dma_reads_g2),
        .tmo_err(tmo_err_g2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dma_hold = 1'b0; dma_cs = 1'b0; cpu_ba = 1'b0;
        cpu_vma = 1'b0; cpu_we = 1'b0;
        repeat (10) step();
    endtask

    // Both instances reach GRANT: GUARD=0 two edges after hold, GUARD=2 four
    task automatic enter_grant();
        step(); dma_hold = 1'b1;
        step(); cpu_ba = 1'b1;
        step(); step(); step();
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_vma = 1'b0;
        cpu_ba = 1'b0; dma_hold = 1'b0; dma_cs = 1'b0; dma_addr = '0; mem_rdata = '0;
        step(); step();
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'hFF);
        @(negedge clk);
        e = exp_q.pop_front(); vecs++;
        if (32'({cpu_halt_g0, dma_grant_g0, mem_cs_g0, mem_we_g0, tmo_err_g0}) !== e) begin
            errs++; $display("FAIL reset_ctl: got %0h exp %0h",
                {cpu_halt_g0, dma_grant_g0, mem_cs_g0, mem_we_g0, tmo_err_g0}, e);
        end
        e = exp_q.pop_front(); vecs++;
        if (32'(dma_reads_g0) !== e) begin
            errs++; $display("FAIL reset_reads: got %0h exp %0h", dma_reads_g0, e);
        end
        e = exp_q.pop_front(); vecs++;
        if (32'(dma_rdata_g0) !== e) begin
            errs++; $display("FAIL reset_dma_rdata: got %0h exp %0h", dma_rdata_g0, e);
        end
        step(); rst = 1'b0;
    endtask

    task automatic test_cpu_write();
        cpu_vma = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'h5A;
        mem_rdata = 8'hC3;
        exp_q.push_back(32'({1'b1, 1'b1, 16'h1234, 8'h5A}));
        exp_q.push_back(32'({1'b1, 1'b1, 16'h1234, 8'h5A}));
        exp_q.push_back(32'({8'hC3, 8'hC3, 8'hFF}));
        @(negedge clk);
        e = exp_q.pop_front(); vecs++;
        if (32'({mem_cs_g0, mem_we_g0, mem_addr_g0, mem_wdata_g0}) !== e) begin
            errs++; $display("FAIL cpu_write_g0: got %0h exp %0h",
                {mem_cs_g0, mem_we_g0, mem_addr_g0, mem_wdata_g0}, e);
        end
        e = exp_q.pop_front(); vecs++;
        if (32'({mem_cs_g2, mem_we_g2, mem_addr_g2, mem_wdata_g2}) !== e) begin
            errs++; $display("FAIL cpu_write_g2: got %0h exp %0h",
                {mem_cs_g2, mem_we_g2, mem_addr_g2, mem_wdata_g2}, e);
        end
        e = exp_q.pop_front(); vecs++;
        if (32'({cpu_rdata_g0, cpu_rdata_g2, dma_rdata_g2}) !== e) begin
            errs++; $display("FAIL cpu_rdata: got %0h exp %0h",
                {cpu_rdata_g0, cpu_rdata_g2, dma_rdata_g2}, e);
        end
        step(); cpu_vma = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic test_basic_grant();
        step(); dma_hold = 1'b1;
        exp_q.push_back(32'd0);
        @(negedge clk);
        e = exp_q.pop_front(); vecs++;
        if (32'(cpu_halt_g0) !== e) begin
            errs++; $display("FAIL halt_early: got %0h exp %0h", cpu_halt_g0, e);
        end
        step(); cpu_ba = 1'b1;
        exp_q.push_back(32'b10);
        @(negedge clk);
        e = exp_q.pop_front(); vecs++;
        if (32'({cpu_halt_g0, dma_grant_g0}) !== e) begin
            errs++; $display("FAIL halt_rise: got %0h exp %0h", {cpu_halt_g0, dma_grant_g0}, e);
        end
        step(); dma_addr = 16'h8000; dma_cs = 1'b1; mem_rdata = 8'hA5;
        exp_q.push_back(32'({1'b1, 1'b1, 1'b0, 16'h8000}));
        exp_q.push_back(32'({8'hA5, 8'hC3}));
        @(negedge clk);
        e = exp_q.pop_front(); vecs++;
        if (32'({dma_grant_g0, mem_cs_g0, mem_we_g0, mem_addr_g0}) !== e) begin
            errs++; $display("FAIL grant_port: got %0h exp %0h",
                {dma_grant_g0, mem_cs_g0, mem_we_g0, mem_addr_g0}, e);
        end
        e = exp_q.pop_front(); vecs++;
        if (32'({dma_rdata_g0, cpu_rdata_g0}) !== e) begin
            errs++; $display("FAIL grant_rdata: got %0h exp %0h", {dma_rdata_g0, cpu_rdata_g0}, e);
        end
        // cpu_ba dropping while granted must not take the bus away
        step(); cpu_ba = 1'b0;
        step();
        exp_q.push_back(32'd1);
        @(negedge clk);
        e = exp_q.pop_front(); vecs++;
        if (32'(dma_grant_g0) !== e) begin
            errs++; $display("FAIL ba_drop_grant: got %0h exp %0h", dma_grant_g0, e);
        end
        dma_hold = 1'b0; dma_cs = 1'b0;
        step();
        exp_q.push_back(32'({1'b0, 1'b0, 8'd2}));
        @(negedge clk);
        e = exp_q.pop_front(); vecs++;
        if (32'({cpu_halt_g0, dma_grant_g0, dma_reads_g0}) !== e) begin
            errs++; $display("FAIL grant_exit: got %0h exp %0h",
                {cpu_halt_g0, dma_grant_g0, dma_reads_g0}, e);
        end
        idle();
    endtask

    task automatic test_read_count(input int n);
        int model = 0;
        step(); dma_hold = 1'b1;
        step(); cpu_ba = 1'b1;
        step(); dma_cs = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            if (model < 255) model++;
        end
        dma_hold = 1'b0; dma_cs = 1'b0;
        exp_q.push_back(32'({1'b0, 8'hFF, 8'(model)}));
        step();
        @(negedge clk);
        e = exp_q.pop_front(); vecs++;
        if (32'({cpu_halt_g0, dma_rdata_g0, dma_reads_g0}) !== e) begin
            errs++; $display("FAIL read_count_%0d: got %0h exp %0h", n,
                {cpu_halt_g0, dma_rdata_g0, dma_reads_g0}, e);
        end
        idle();
    endtask

    task automatic test_guard();
        cpu_vma = 1'b1; dma_cs = 1'b1; dma_addr = 16'h4321;
        step(); dma_hold = 1'b1;
        step(); cpu_ba = 1'b1;
        exp_q.push_back(32'b01); exp_q.push_back(32'b00);
        exp_q.push_back(32'b00); exp_q.push_back(32'b11);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            @(negedge clk);
            e = exp_q.pop_front(); vecs++;
            if (32'({dma_grant_g2, mem_cs_g2}) !== e) begin
                errs++; $display("FAIL guard_in_%0d: got %0h exp %0h", k, {dma_grant_g2, mem_cs_g2}, e);
            end
        end
        step(); dma_hold = 1'b0;
        exp_q.push_back(32'b100); exp_q.push_back(32'b100); exp_q.push_back(32'b001);
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            e = exp_q.pop_front(); vecs++;
            if (32'({cpu_halt_g2, dma_grant_g2, mem_cs_g2}) !== e) begin
                errs++; $display("FAIL guard_out_%0d: got %0h exp %0h", k,
                    {cpu_halt_g2, dma_grant_g2, mem_cs_g2}, e);
            end
        end
        exp_q.push_back(32'd1);
        e = exp_q.pop_front(); vecs++;
        if (32'(dma_reads_g2) !== e) begin
            errs++; $display("FAIL guard_reads: got %0h exp %0h", dma_reads_g2, e);
        end
        idle();
    endtask

    task automatic test_abort();
        logic seen = 1'b0;
        step(); dma_hold = 1'b1;
        step(); dma_hold = 1'b0;
        exp_q.push_back(32'd1);
        @(negedge clk);
        e = exp_q.pop_front(); vecs++;
        if (32'(cpu_halt_g0) !== e) begin
            errs++; $display("FAIL abort_halt: got %0h exp %0h", cpu_halt_g0, e);
        end
        seen = dma_grant_g0 | dma_grant_g2;
        step();
        exp_q.push_back(32'b000);
        @(negedge clk);
        seen = seen | dma_grant_g0 | dma_grant_g2;
        e = exp_q.pop_front(); vecs++;
        if (32'({cpu_halt_g0, cpu_halt_g2, seen}) !== e) begin
            errs++; $display("FAIL abort_release: got %0h exp %0h", {cpu_halt_g0, cpu_halt_g2, seen}, e);
        end
        idle();
    endtask

    // Hold drop and cpu_ba rise on the same edge: the drop wins
    task automatic test_same_edge();
        step(); dma_hold = 1'b1;
        step(); dma_hold = 1'b0; cpu_ba = 1'b1;
        step();
        exp_q.push_back(32'b00);
        @(negedge clk);
        e = exp_q.pop_front(); vecs++;
        if (32'({cpu_halt_g0, dma_grant_g0}) !== e) begin
            errs++; $display("FAIL same_edge: got %0h exp %0h", {cpu_halt_g0, dma_grant_g0}, e);
        end
        idle();
    endtask

    task automatic test_hold_in_guard_out();
        enter_grant();
        step(); dma_hold = 1'b0;
        step(); dma_hold = 1'b1;
        exp_q.push_back(32'b10); exp_q.push_back(32'b00); exp_q.push_back(32'b10);
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            e = exp_q.pop_front(); vecs++;
            if (32'({cpu_halt_g2, dma_grant_g2}) !== e) begin
                errs++; $display("FAIL rehold_%0d: got %0h exp %0h", k, {cpu_halt_g2, dma_grant_g2}, e);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid_grant();
        enter_grant();
        cpu_vma = 1'b1; cpu_addr = 16'h0ABC; dma_cs = 1'b1; rst = 1'b1;
        exp_q.push_back(32'b00);
        @(negedge clk);
        e = exp_q.pop_front(); vecs++;
        if (32'({mem_cs_g0, mem_cs_g2}) !== e) begin
            errs++; $display("FAIL rst_grant_cs: got %0h exp %0h", {mem_cs_g0, mem_cs_g2}, e);
        end
        step(); rst = 1'b0;
        exp_q.push_back(32'({1'b0, 1'b0, 1'b1, 16'h0ABC, 8'd0}));
        @(negedge clk);
        e = exp_q.pop_front(); vecs++;
        if (32'({dma_grant_g0, cpu_halt_g0, mem_cs_g0, mem_addr_g0, dma_reads_g0}) !== e) begin
            errs++; $display("FAIL rst_grant_port: got %0h exp %0h",
                {dma_grant_g0, cpu_halt_g0, mem_cs_g0, mem_addr_g0, dma_reads_g0}, e);
        end
        idle();
    endtask

    task automatic test_timeout();
        logic tmo_on;
`ifdef VRAM_ARB_TIMEOUT_EN
        tmo_on = 1'b1;
`else
        tmo_on = 1'b0;
`endif
        step(); dma_hold = 1'b1;
        repeat (10) step();
        exp_q.push_back(32'b10);
        @(negedge clk);
        e = exp_q.pop_front(); vecs++;
        if (32'({cpu_halt_g0, tmo_err_g0}) !== e) begin
            errs++; $display("FAIL tmo_before: got %0h exp %0h", {cpu_halt_g0, tmo_err_g0}, e);
        end
        step();
        exp_q.push_back(32'({!tmo_on, tmo_on}));
        @(negedge clk);
        e = exp_q.pop_front(); vecs++;
        if (32'({cpu_halt_g0, tmo_err_g0}) !== e) begin
            errs++; $display("FAIL tmo_fire: got %0h exp %0h", {cpu_halt_g0, tmo_err_g0}, e);
        end
        repeat (3) step();
        exp_q.push_back(32'({!tmo_on, tmo_on, !tmo_on, tmo_on}));
        @(negedge clk);
        e = exp_q.pop_front(); vecs++;
        if (32'({cpu_halt_g0, tmo_err_g0, cpu_halt_g2, tmo_err_g2}) !== e) begin
            errs++; $display("FAIL tmo_hold_ignored: got %0h exp %0h",
                {cpu_halt_g0, tmo_err_g0, cpu_halt_g2, tmo_err_g2}, e);
        end
        dma_hold = 1'b0;
        step(); dma_hold = 1'b1;
        step();
        exp_q.push_back(32'({1'b1, tmo_on}));
        @(negedge clk);
        e = exp_q.pop_front(); vecs++;
        if (32'({cpu_halt_g0, tmo_err_g0}) !== e) begin
            errs++; $display("FAIL tmo_rehold: got %0h exp %0h", {cpu_halt_g0, tmo_err_g0}, e);
        end
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cpu_write();
        test_basic_grant();
        test_read_count(40);
        test_read_count(300);
        test_guard();
        test_abort();
        test_same_edge();
        test_hold_in_guard_out();
        test_reset_mid_grant();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
